// File: rtl/seq_gen_param.sv
// seq_gen_param: start-triggered sequence engine. Loads two seeds, then
// iterates a selectable two-term recurrence, emitting one registered term per
// cycle for a programmable count, and closes with a one-cycle done pulse.
module seq_gen_param #(
    parameter int WIDTH   = 16,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [WIDTH-1:0]   init0,
    input  logic [WIDTH-1:0]   init1,
    input  logic [COUNT_W-1:0] n_terms,
    output logic [WIDTH-1:0]   seq_out,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD0 = 3'd1,
        S_LOAD1 = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // One recurrence step: returns {wrap_flag, next_term}.
    function automatic logic [WIDTH:0] step_fn(input logic [1:0]       m,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] res;
        case (m)
            2'b00:   res = {1'b0, a} + {1'b0, b};                 // carry-out is the wrap
            2'b01:   res = {(a > b), b - a};                      // borrow when R0 > R1
            2'b10:   res = {b[WIDTH-1], b[WIDTH-2:0], 1'b0};      // MSB shifted out
            2'b11:   res = {1'b0, a ^ b};
            default: res = {1'b0, a ^ b};
        endcase
        return res;
    endfunction

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [WIDTH-1:0]     init0_q, init0_d;
    logic [WIDTH-1:0]     init1_q, init1_d;
    logic [COUNT_W-1:0]   n_q, n_d;
    logic [WIDTH-1:0]     r0_q, r0_d;
    logic [WIDTH-1:0]     r1_q, r1_d;
    logic [COUNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]     seq_out_q, seq_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 overflow_q, overflow_d;
    logic [WIDTH:0]       step_s;

    // Next-state and datapath decode; every output is registered from here.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        init0_d     = init0_q;
        init1_d     = init1_q;
        n_d         = n_q;
        r0_d        = r0_q;
        r1_d        = r1_q;
        cnt_d       = cnt_q;
        seq_out_d   = seq_out_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        overflow_d  = overflow_q;
        step_s      = step_fn(mode_q, r0_q, r1_q);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    init0_d    = init0;
                    init1_d    = init1;
                    n_d        = n_terms;
                    overflow_d = 1'b0;
                    if (n_terms == {COUNT_W{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD0: begin
                r0_d        = init0_q;
                seq_out_d   = init0_q;
                out_valid_d = 1'b1;
                cnt_d       = COUNT_W'(1);
                if (n_q == COUNT_W'(1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD1;
                end
            end
            S_LOAD1: begin
                r1_d        = init1_q;
                seq_out_d   = init1_q;
                out_valid_d = 1'b1;
                cnt_d       = COUNT_W'(2);
                if (n_q == COUNT_W'(2)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                r0_d        = r1_q;
                r1_d        = step_s[WIDTH-1:0];
                seq_out_d   = step_s[WIDTH-1:0];
                out_valid_d = 1'b1;
                cnt_d       = cnt_q + COUNT_W'(1);
                overflow_d  = overflow_q | step_s[WIDTH];
                if (cnt_d == n_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mode_q      <= 2'b00;
            init0_q     <= {WIDTH{1'b0}};
            init1_q     <= {WIDTH{1'b0}};
            n_q         <= {COUNT_W{1'b0}};
            r0_q        <= {WIDTH{1'b0}};
            r1_q        <= {WIDTH{1'b0}};
            cnt_q       <= {COUNT_W{1'b0}};
            seq_out_q   <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            init0_q     <= init0_d;
            init1_q     <= init1_d;
            n_q         <= n_d;
            r0_q        <= r0_d;
            r1_q        <= r1_d;
            cnt_q       <= cnt_d;
            seq_out_q   <= seq_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
        end
    end

    assign seq_out   = seq_out_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/seq_gen_param.md
Name: seq_gen_param

Overview:
Parametrised sequence engine that replaces the fixed two-step R0/R1 controller with an integrated controller and datapath.
- On a start pulse it loads two seed values into R0/R1.
- It then iterates a selectable recurrence, emitting one term per cycle for a programmable number of terms.
- It finishes with a one-cycle done pulse.
- It sits as a self-contained sequence source feeding downstream consumers through seq_out/out_valid.

Parameters:
- WIDTH, 16, datapath width of R0, R1, seeds and seq_out.
- COUNT_W, 8, width of the term counter and n_terms; max sequence length 2^COUNT_W-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- mode  in  2  recurrence select, captured at start: 00 add (R0+R1), 01 sub (R1-R0), 10 shift (R1<<1), 11 xor (R0^R1).
- init0  in  WIDTH  first seed, captured at start.
- init1  in  WIDTH  second seed, captured at start.
- n_terms  in  COUNT_W  number of terms to emit, captured at start.
- seq_out  out  WIDTH  current term, registered.
- out_valid  out  1  seq_out holds a new term this cycle.
- busy  out  1  high from the cycle after start is accepted until DONE inclusive.
- done  out  1  one-cycle pulse after the last term.
- overflow  out  1  sticky flag for arithmetic wrap; cleared on the next accepted start.

Behaviour:
- Reset (async): state=IDLE; R0, R1, counter, seq_out, out_valid, busy, done, overflow all 0. Reset mid-sequence aborts immediately with no done pulse.
- States: IDLE, LOAD0, LOAD1, RUN, DONE.
- IDLE:
  - On an edge with start=1: capture mode, init0, init1 and n_terms; clear overflow.
  - Go to DONE if n_terms=0, else LOAD0.
  - start=0: remain in IDLE.
- LOAD0 edge: R0<=init0, seq_out<=init0, out_valid<=1, cnt<=1. Next state is DONE if n=1, else LOAD1.
- LOAD1 edge: R1<=init1, seq_out<=init1, out_valid<=1, cnt<=2. Next state is DONE if n=2, else RUN.
- RUN edge:
  - next=f(mode,R0,R1), taken mod 2^WIDTH.
  - R0<=R1, R1<=next, seq_out<=next, out_valid<=1, cnt<=cnt+1.
  - Go to DONE when cnt+1==n.
- DONE: done=1 and out_valid=0 for exactly one cycle, then IDLE. busy=0 from IDLE onward.
- Latency:
  - Term k (1-based) is valid on the cycle after the k-th edge following the start-sampling edge.
  - Terms are back-to-back with no gaps.
  - done occurs the cycle after the last term.
  - From start to IDLE takes n+2 cycles (n≥1).
- out_valid is 0 in IDLE and DONE. seq_out holds its last value when out_valid=0.
- overflow sets on:
  - add carry-out;
  - sub borrow (R0>R1 unsigned);
  - shift when R1[WIDTH-1]=1.
  - xor never sets it.
- start while busy is ignored: no restart, captured values unchanged.
- start asserted in the DONE cycle is ignored. start held high continuously re-launches from IDLE every n+2 cycles.
- n_terms, mode and seed changes after capture have no effect on the running sequence.

Test Plan:
- Fibonacci: reset, then start with mode=00, init0=0, init1=1, n=8 → seq_out 0,1,1,2,3,5,8,13 on 8 consecutive valid cycles; done=1 the next cycle; overflow=0.
- Boundaries:
  - n=0 → no out_valid, done pulses one cycle after busy rises, with busy high only in that DONE cycle.
  - n=1, init0=0x00AA → single term 0x00AA, then done.
  - n=2 → exactly init0 then init1.
- Sub wrap (WIDTH=16): mode=01, init0=5, init1=3, n=3 → 5, 3, 0xFFFE; overflow=1 and held after done; next start clears it.
- Shift: mode=10, init0=0, init1=0x4000, n=4 → 0, 0x4000, 0x8000, 0x0000; overflow=1 on the 4th term.
- Start while busy: a second start mid-run with different seeds → the original sequence completes unchanged and only one done pulse occurs.
- Reset mid-run: assert reset during RUN → all outputs 0 immediately (asynchronously), no done; a fresh start afterwards produces the correct full sequence.
